// File: rtl/riscv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_pkg
// Purpose  : Shared types and constants for the single-cycle RISC-V core.
// Revision : 1.0
// ============================================================================
package riscv_core_pkg;

    localparam int              XLEN                 = 32;
    localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_target_select.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_select
// Purpose  : Next-PC priority mux (trap > redirect > sequential) with pending
//            redirect bookkeeping while a fetch is outstanding.
// Revision : 1.0
// ============================================================================
module pc_target_select
    import riscv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_transfer,
    input  logic            i_outstanding,
    input  logic            i_trap,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_pend_valid,
    input  logic            i_pend_trap,
    input  logic [XLEN-1:0] i_pend_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_squash,
    output logic            o_pend_valid,
    output logic            o_pend_trap,
    output logic [XLEN-1:0] o_pend_target,
    output logic            o_misaligned
);

    logic            w_new_ev;
    logic            w_new_trap;
    logic [XLEN-1:0] w_new_tgt;
    logic            w_cand_valid;
    logic            w_cand_trap;
    logic [XLEN-1:0] w_cand_tgt;

    always_comb begin
        o_misaligned = i_redirect_valid && !i_trap && (i_redirect_target[1:0] != 2'b00);
        w_new_ev     = i_trap || i_redirect_valid;
        w_new_trap   = i_trap || o_misaligned;
        w_new_tgt    = w_new_trap ? TRAP_VECTOR : i_redirect_target;

        // A stored trap is never displaced by a later plain redirect.
        if (i_pend_valid && (!w_new_ev || (i_pend_trap && !w_new_trap))) begin
            w_cand_trap = i_pend_trap;
            w_cand_tgt  = i_pend_target;
        end else begin
            w_cand_trap = w_new_trap;
            w_cand_tgt  = w_new_tgt;
        end
        w_cand_valid = i_pend_valid || w_new_ev;

        o_next_pc     = i_pc;
        o_squash      = 1'b0;
        o_pend_valid  = 1'b0;
        o_pend_trap   = 1'b0;
        o_pend_target = i_pend_target;

        if (i_outstanding) begin
            o_pend_valid  = w_cand_valid;
            o_pend_trap   = w_cand_trap;
            o_pend_target = w_cand_tgt;
            o_squash      = w_new_ev;
        end else if (w_cand_valid) begin
            o_next_pc = w_cand_tgt;
            o_squash  = 1'b1;
        end else if (i_transfer) begin
            o_next_pc = i_pc + PC_STEP;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-side PC owner: boot delay, imem req/ready fetch, decode
//            valid/stall delivery, redirect/trap handling and halt/resume.
// Revision : 1.0
// ============================================================================
module pc_sequencer
    import riscv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int unsigned     BOOT_DELAY   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            halt,
    input  logic            resume,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc,
    output logic            misaligned_err
);

    localparam int unsigned      c_cnt_w     = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [c_cnt_w-1:0] c_boot_last = c_cnt_w'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [c_cnt_w-1:0] r_boot_cnt;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_instr;
    logic [XLEN-1:0]    r_instr_pc;
    logic               r_instr_valid;
    logic               r_req_held;
    logic               r_pend_valid;
    logic               r_pend_trap;
    logic [XLEN-1:0]    r_pend_target;
    logic               r_mis;

    logic               w_req;
    logic               w_transfer;
    logic               w_outstanding;
    logic [XLEN-1:0]    w_next_pc;
    logic               w_squash;
    logic               w_pend_valid;
    logic               w_pend_trap;
    logic [XLEN-1:0]    w_pend_target;
    logic               w_mis;

    // halt only withdraws a request that the memory has not yet been held on
    assign w_req = (r_state == ST_FETCH) && !(r_instr_valid && stall) && !(halt && !r_req_held);
    assign w_transfer    = w_req && imem_ready;
    assign w_outstanding = w_req && !imem_ready;

    pc_target_select #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_sel (
        .i_pc              (r_pc),
        .i_transfer        (w_transfer),
        .i_outstanding     (w_outstanding),
        .i_trap            (trap),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_pend_valid      (r_pend_valid),
        .i_pend_trap       (r_pend_trap),
        .i_pend_target     (r_pend_target),
        .o_next_pc         (w_next_pc),
        .o_squash          (w_squash),
        .o_pend_valid      (w_pend_valid),
        .o_pend_trap       (w_pend_trap),
        .o_pend_target     (w_pend_target),
        .o_misaligned      (w_mis)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:   if ((BOOT_DELAY == 0) || (r_boot_cnt == c_boot_last)) w_state_next = ST_FETCH;
            ST_FETCH:  if (halt && !w_outstanding) w_state_next = ST_HALTED;
            ST_HALTED: if (resume && !halt) w_state_next = ST_FETCH;
            default:   w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_boot_cnt    <= '0;
            r_pc          <= RESET_VECTOR;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_req_held    <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_trap   <= 1'b0;
            r_pend_target <= '0;
            r_mis         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            if (r_state == ST_BOOT) r_boot_cnt <= r_boot_cnt + 1'b1;
            r_pc          <= w_next_pc;
            r_req_held    <= w_outstanding;
            r_pend_valid  <= w_pend_valid;
            r_pend_trap   <= w_pend_trap;
            r_pend_target <= w_pend_target;
            r_mis         <= w_mis;
            if (w_squash) begin
                r_instr_valid <= 1'b0;
            end else if (w_transfer) begin
                r_instr       <= imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end else if (!stall) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign imem_req       = w_req;
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign instr_valid    = r_instr_valid;
    assign misaligned_err = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer with a delivery
//            scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic        halt;
    logic        resume;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        misaligned_err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] sb_e;
    logic        m_pv;
    logic        m_ps;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return a ^ 32'h00A0_0093;
    endfunction

    assign imem_rdata = exp_word(imem_addr);

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .BOOT_DELAY   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .halt            (halt),
        .resume          (resume),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .pc              (pc),
        .misaligned_err  (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb_q.push_back({exp_word(a), a});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop one expectation on every newly delivered instruction.
    always @(negedge clk) begin
        if (rst) begin
            m_pv = 1'b0;
            m_ps = 1'b0;
        end else begin
            if (instr_valid && !(m_pv && m_ps)) begin
                n_assert++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected: observed delivery pc 0x%08h expected none", instr_pc);
                end
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    chk("sb_instr", instr, sb_e[63:32]);
                    chk("sb_instr_pc", instr_pc, sb_e[31:0]);
                end
            end
            m_pv = instr_valid;
            m_ps = stall;
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap = 1'b0; halt = 1'b0; resume = 1'b0; imem_ready = 1'b1;
        repeat (3) step();

        // C0: first cycle with rst low, reset values visible
        rst = 1'b0; #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_mis", {31'b0, misaligned_err}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            step(); #1;
            chk("boot_idle_req", {31'b0, imem_req}, 32'd0);
        end

        // C4..C7: back-to-back fetch
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, 32'(i * 4));
            push(32'(i * 4));
        end

        // C8..C10: stall holds the delivered word
        for (int i = 0; i < 3; i++) begin
            step(); stall = 1'b1; #1;
            chk("stall_instr", instr, exp_word(32'hC));
            chk("stall_instr_pc", instr_pc, 32'hC);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_addr", imem_addr, 32'h10);
        end

        // C11..C14: outstanding fetch at 0x10 redirected to 0x200
        step(); stall = 1'b0; imem_ready = 1'b0; #1;
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h10);
        step(); redirect_valid = 1'b1; redirect_target = 32'h200; #1;
        chk("pend_req", {31'b0, imem_req}, 32'd1);
        chk("pend_addr_hold", imem_addr, 32'h10);
        step(); redirect_valid = 1'b0; imem_ready = 1'b1; #1;
        chk("pend_complete_addr", imem_addr, 32'h10);
        step(); #1;
        chk("pend_drop_valid", {31'b0, instr_valid}, 32'd0);
        chk("pend_new_addr", imem_addr, 32'h200);
        push(32'h200);

        // C15..C17: trap beats redirect; then misaligned redirect
        step(); trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300; #1;
        chk("trap_pre_addr", imem_addr, 32'h204);
        step(); trap = 1'b0; redirect_target = 32'h302; #1;
        chk("trap_pc", pc, 32'h100);
        chk("trap_mis", {31'b0, misaligned_err}, 32'd0);
        chk("trap_squash", {31'b0, instr_valid}, 32'd0);
        step(); redirect_valid = 1'b0; #1;
        chk("mis_pc", pc, 32'h100);
        chk("mis_pulse", {31'b0, misaligned_err}, 32'd1);
        chk("mis_squash", {31'b0, instr_valid}, 32'd0);
        push(32'h100);

        // C18..C24: halt during outstanding fetch, then resume
        step(); imem_ready = 1'b0; #1;
        chk("mis_clear", {31'b0, misaligned_err}, 32'd0);
        chk("halt_pre_addr", imem_addr, 32'h104);
        step(); halt = 1'b1; #1;
        chk("halt_hold_req", {31'b0, imem_req}, 32'd1);
        chk("halt_hold_addr", imem_addr, 32'h104);
        step(); imem_ready = 1'b1; #1;
        chk("halt_complete_req", {31'b0, imem_req}, 32'd1);
        push(32'h104);
        step(); #1;
        chk("halted_req", {31'b0, imem_req}, 32'd0);
        chk("halted_pc", pc, 32'h108);
        step(); halt = 1'b0; #1;
        chk("halted_idle_req", {31'b0, imem_req}, 32'd0);
        step(); resume = 1'b1; #1;
        chk("resume_cycle_req", {31'b0, imem_req}, 32'd0);
        step(); resume = 1'b0; imem_ready = 1'b0; #1;
        chk("refetch_req", {31'b0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'h108);

        // C25..C32: reset with a pending redirect
        step(); redirect_valid = 1'b1; redirect_target = 32'h400; #1;
        chk("pend2_addr", imem_addr, 32'h108);
        step(); redirect_valid = 1'b0; rst = 1'b1; imem_ready = 1'b1; #1;
        step(); rst = 1'b0; #1;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst2_req", {31'b0, imem_req}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            step(); #1;
            chk("rst2_boot_req", {31'b0, imem_req}, 32'd0);
        end
        step(); #1;
        chk("rst2_first_req", {31'b0, imem_req}, 32'd1);
        chk("rst2_first_addr", imem_addr, 32'h0);
        push(32'h0);
        step(); imem_ready = 1'b0; #1;
        chk("rst2_next_addr", imem_addr, 32'h4);
        step();
        step();

        n_assert++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover: observed %0d undelivered expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
